// File: rtl/fifo_uart_unpack.sv
// Pops words from a standard-read FIFO and serializes each one MSB byte first
// into single-byte start pulses for the UART transmitter.
module fifo_uart_unpack #(
  parameter int WORD_W = 128,
  parameter int BYTE_W = 8
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              tx_en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] fifo_rd_data,
  output logic [BYTE_W-1:0] uart_tx_data,
  output logic              uart_tx_vld,
  input  logic              uart_tx_busy,
  output logic              word_done,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int BYTE_NUM = WORD_W / BYTE_W;
  localparam int CNT_W    = $clog2(BYTE_NUM);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    LOAD    = 3'd2,
    SEND    = 3'd3,
    GUARD   = 3'd4,
    WAIT    = 3'd5
  } state_t;

  state_t              state, state_d;
  logic [WORD_W-1:0]   shreg, shreg_d;
  logic [CNT_W-1:0]    byte_cnt, byte_cnt_d;
  logic [BYTE_W-1:0]   tx_data_d;
  logic                rd_en_d, tx_vld_d, word_done_d, busy_d;

  // Handshake: uart_tx_vld is a one-cycle start pulse issued only when
  // uart_tx_busy is low; busy is ignored for the GUARD cycle because the
  // transmitter raises it one cycle after the pulse.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    byte_cnt_d  = byte_cnt;
    tx_data_d   = uart_tx_data;
    rd_en_d     = 1'b0;
    tx_vld_d    = 1'b0;
    word_done_d = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: state_d = LOAD;
      LOAD: begin
        shreg_d    = fifo_rd_data;
        byte_cnt_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (!uart_tx_busy) begin
          tx_data_d = shreg[WORD_W-1 -: BYTE_W];
          tx_vld_d  = 1'b1;
          state_d   = GUARD;
        end
      end
      GUARD: state_d = WAIT;
      WAIT: begin
        if (!uart_tx_busy) begin
          if (byte_cnt == LAST_BYTE) begin
            word_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            shreg_d    = shreg << BYTE_W;
            byte_cnt_d = byte_cnt + CNT_W'(1);
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Derived from the next state so the registered flag tracks the state register.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      byte_cnt     <= '0;
      uart_tx_data <= '0;
      fifo_rd_en   <= 1'b0;
      uart_tx_vld  <= 1'b0;
      word_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      shreg        <= shreg_d;
      byte_cnt     <= byte_cnt_d;
      uart_tx_data <= tx_data_d;
      fifo_rd_en   <= rd_en_d;
      uart_tx_vld  <= tx_vld_d;
      word_done    <= word_done_d;
      busy         <= busy_d;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fifo_uart_unpack.sv
// Directed bench for fifo_uart_unpack with a FIFO model, a UART TX busy model
// and a byte scoreboard fed from the words the FIFO model hands out.
module tb_fifo_uart_unpack;

  logic         s_clk = 1'b0;
  logic         s_rst_n;
  logic         tx_en;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [127:0] fifo_rd_data;
  logic [7:0]   uart_tx_data;
  logic         uart_tx_vld;
  logic         uart_tx_busy;
  logic         word_done;
  logic         busy;
  logic [2:0]   dbg_state;

  logic         model_busy;
  logic         stall_busy;
  int           busy_left;

  logic [127:0] fifo_mem[16];
  int           push_cnt = 0;
  int           pop_cnt = 0;

  logic [7:0]   exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           rd_cnt = 0;
  int           wd_cnt = 0;
  int           byte_total = 0;
  int           byte_in_word = 0;

  localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W1 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] W2 = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;
  localparam logic [127:0] W3 = 128'hA5A4A3A2_A1A09F9E_9D9C9B9A_99989796;
  localparam logic [127:0] W4 = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;
  localparam logic [127:0] W5 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
  localparam logic [127:0] W6 = 128'h7F6E5D4C_3B2A1908_F7E6D5C4_B3A29180;

  typedef struct {
    logic tx_en;
    logic push;
    int   cycles;
    logic exp_rd_en;
    logic exp_vld;
    logic exp_busy;
  } vec_t;

  vec_t vecs[7];

  fifo_uart_unpack dut (
    .s_clk        (s_clk),
    .s_rst_n      (s_rst_n),
    .tx_en        (tx_en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .uart_tx_data (uart_tx_data),
    .uart_tx_vld  (uart_tx_vld),
    .uart_tx_busy (uart_tx_busy),
    .word_done    (word_done),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  always #5 s_clk = ~s_clk;

  assign fifo_empty   = (push_cnt == pop_cnt);
  assign uart_tx_busy = model_busy | stall_busy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO model: read data appears after the edge that samples fifo_rd_en.
  always @(posedge s_clk) begin
    if (fifo_rd_en) begin
      #1;
      fifo_rd_data = fifo_mem[pop_cnt % 16];
      pop_cnt = pop_cnt + 1;
    end
  end

  // UART TX model: busy rises the cycle after vld and stays high 10 cycles.
  always @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      model_busy = 1'b0;
      busy_left  = 0;
    end else if (uart_tx_vld) begin
      busy_left = 10;
      #1 model_busy = 1'b1;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) #1 model_busy = 1'b0;
    end
  end

  // scoreboard
  always @(negedge s_clk) begin
    logic [127:0] w;
    logic [7:0]   e;
    if (!s_rst_n) begin
      exp_q.delete();
      byte_in_word = 0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        check("rd_en_nonempty", 128'(pop_cnt < push_cnt), 128'd1);
        exp_q.delete();
        byte_in_word = 0;
        w = fifo_mem[pop_cnt % 16];
        for (int i = 0; i < 16; i++) exp_q.push_back(w[127 - 8*i -: 8]);
      end
      if (uart_tx_vld) begin
        check("vld_while_busy", 128'(uart_tx_busy), 128'd0);
        check("byte_pending", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_byte", 128'(uart_tx_data), 128'(e));
        end
        byte_total++;
        byte_in_word++;
      end
      if (word_done) begin
        wd_cnt++;
        check("word_done_bytes", 128'(byte_in_word), 128'd16);
        check("word_done_after_busy", 128'(uart_tx_busy), 128'd0);
      end
    end
  end

  // driver tasks
  task automatic push_word(input logic [127:0] w);
    fifo_mem[push_cnt % 16] = w;
    push_cnt = push_cnt + 1;
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int n = 0;
    while (wd_cnt < target && n < budget) begin
      @(negedge s_clk);
      n++;
    end
    check(name, 128'(wd_cnt), 128'(target));
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rd_en"}, 128'(fifo_rd_en), 128'd0);
    check({name, "_vld"}, 128'(uart_tx_vld), 128'd0);
    check({name, "_data"}, 128'(uart_tx_data), 128'd0);
    check({name, "_word_done"}, 128'(word_done), 128'd0);
    check({name, "_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int n;
    int b0;
    s_rst_n    = 1'b0;
    tx_en      = 1'b0;
    stall_busy = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 50, 1'b0, 1'b0, 1'b0};  // empty, enabled
    vecs[1] = '{1'b0, 1'b1, 50, 1'b0, 1'b0, 1'b0};  // non-empty, disabled
    vecs[2] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1};  // RD_WAIT: pop strobe
    vecs[3] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1};  // LOAD
    vecs[4] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1};  // SEND decides
    vecs[5] = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1};  // first vld, 3 cycles after pop
    vecs[6] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1};  // WAIT

    repeat (3) @(negedge s_clk);
    check_outputs_zero("reset");
    check("reset_state", 128'(dbg_state), 128'd0);
    s_rst_n = 1'b1;
    @(negedge s_clk);

    // table: idle behaviour and start of the single-word case
    for (int v = 0; v < 7; v++) begin
      tx_en = vecs[v].tx_en;
      if (vecs[v].push) push_word(W0);
      for (int c = 0; c < vecs[v].cycles; c++) begin
        @(negedge s_clk);
        check($sformatf("vec%0d_rd_en", v), 128'(fifo_rd_en), 128'(vecs[v].exp_rd_en));
        check($sformatf("vec%0d_vld", v), 128'(uart_tx_vld), 128'(vecs[v].exp_vld));
        check($sformatf("vec%0d_busy", v), 128'(busy), 128'(vecs[v].exp_busy));
      end
    end
    wait_words(1, 1000, "single_word_done");
    repeat (5) @(negedge s_clk);
    check("single_rd_cnt", 128'(rd_cnt), 128'd1);
    check("single_bytes", 128'(byte_total), 128'd16);

    // two words back-to-back
    push_word(W1);
    push_word(W2);
    wait_words(3, 2000, "b2b_done");
    repeat (5) @(negedge s_clk);
    check("b2b_rd_cnt", 128'(rd_cnt), 128'd3);
    check("b2b_bytes", 128'(byte_total), 128'd48);

    // tx_en dropped after byte 5 with two words still queued
    push_word(W3);
    push_word(W4);
    push_word(W5);
    n = 0;
    while (!(rd_cnt == 4 && byte_in_word >= 5) && n < 1000) begin
      @(negedge s_clk);
      n++;
    end
    check("drop_reached_byte5", 128'(byte_in_word), 128'd5);
    tx_en = 1'b0;
    wait_words(4, 1000, "drop_word_done");
    repeat (100) @(negedge s_clk);
    check("drop_rd_cnt", 128'(rd_cnt), 128'd4);
    check("drop_busy", 128'(busy), 128'd0);
    check("drop_fifo_level", 128'(push_cnt - pop_cnt), 128'd2);
    check("drop_state", 128'(dbg_state), 128'd0);

    // asynchronous reset during byte 8 of W4
    tx_en = 1'b1;
    n = 0;
    while (!(rd_cnt == 5 && byte_in_word >= 8) && n < 1000) begin
      @(negedge s_clk);
      n++;
    end
    check("rst_reached_byte8", 128'(byte_in_word), 128'd8);
    @(posedge s_clk);
    #3 s_rst_n = 1'b0;
    #1 check_outputs_zero("rst_async");
    repeat (3) begin
      @(negedge s_clk);
      check_outputs_zero("rst_hold");
    end
    s_rst_n = 1'b1;
    wait_words(5, 1000, "rst_next_word_done");
    repeat (5) @(negedge s_clk);
    check("rst_rd_cnt", 128'(rd_cnt), 128'd6);
    check("rst_fifo_level", 128'(push_cnt - pop_cnt), 128'd0);

    // TX already busy on entry to SEND and held for 100 cycles
    stall_busy = 1'b1;
    push_word(W6);
    b0 = byte_total;
    repeat (100) @(negedge s_clk);
    check("stall_no_vld", 128'(byte_total - b0), 128'd0);
    check("stall_state_send", 128'(dbg_state), 128'd3);
    check("stall_busy_out", 128'(busy), 128'd1);
    @(posedge s_clk);
    #1 stall_busy = 1'b0;
    @(posedge s_clk);
    #1 check("stall_vld_next_cycle", 128'(uart_tx_vld), 128'd1);
    check("stall_first_byte", 128'(uart_tx_data), 128'h7F);
    wait_words(6, 1000, "stall_word_done");
    repeat (5) @(negedge s_clk);
    check("final_rd_cnt", 128'(rd_cnt), 128'd7);
    check("final_exp_q_empty", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_unpack.md
Name: fifo_uart_unpack

Overview:
- Read side of the UART loopback path. Pops 128-bit words from a standard (non-show-ahead) FIFO and serializes each word into 16 bytes for the UART transmitter.
- Byte order is MSB-first: bits [127:120] go out first. This is the exact inverse of the UART-to-WFIFO byte packer, so a word received over UART and stored to DDR3 is echoed back in the original byte order.
- Sits between the FIFO read port and the UART TX module.

Parameters:
- WORD_W, 128, FIFO word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, UART symbol width in bits.
- BYTE_NUM, WORD_W/BYTE_W (16), number of bytes per word; a local derived constant, not overridable.

Ports:
- s_clk, input, 1: single system clock; FIFO read port and UART TX share it.
- s_rst_n, input, 1: asynchronous active-low reset.
- tx_en, input, 1: level enable. When 0, no new word is started; a word already in progress completes.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_rd_en, output, 1: FIFO read strobe; one-cycle pulse.
- fifo_rd_data, input, WORD_W: FIFO read data; valid the cycle after fifo_rd_en.
- uart_tx_data, output, BYTE_W: byte to transmit.
- uart_tx_vld, output, 1: one-cycle start pulse to the UART TX.
- uart_tx_busy, input, 1: high while the UART TX is shifting a byte.
- word_done, output, 1: one-cycle pulse after the last byte of a word finishes.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset values: fifo_rd_en=0, uart_tx_vld=0, uart_tx_data=0, word_done=0, busy=0, shift register=0, byte_cnt=0, state=IDLE.
- All outputs are registered.
- Reset asserted mid-word aborts immediately. The partial word is discarded, no further bytes are sent, and the already-popped word is not re-read.
- State machine:
  - IDLE: if tx_en=1 and fifo_empty=0, pulse fifo_rd_en for one cycle and go to RD_WAIT. Otherwise stay in IDLE.
  - RD_WAIT: one cycle; fifo_rd_data becomes valid. Go to LOAD.
  - LOAD: shreg <= fifo_rd_data, byte_cnt <= 0. Go to SEND.
  - SEND: if uart_tx_busy=0, uart_tx_data <= shreg[WORD_W-1 -: BYTE_W] and uart_tx_vld <= 1 for one cycle, then go to GUARD. If uart_tx_busy=1, stay in SEND.
  - GUARD: one cycle in which uart_tx_busy is ignored. This covers the UART TX raising busy one cycle after vld. Go to WAIT.
  - WAIT: stay while uart_tx_busy=1. When uart_tx_busy=0:
    - If byte_cnt=BYTE_NUM-1, pulse word_done and go to IDLE.
    - Otherwise shreg <= shreg << BYTE_W, byte_cnt <= byte_cnt+1, and go to SEND.
- byte_cnt is $clog2(BYTE_NUM) bits wide. It wraps only through LOAD, never through increment past BYTE_NUM-1.
- Exactly one fifo_rd_en per word. fifo_rd_en is never asserted while fifo_empty=1 or outside IDLE, so the FIFO is never underflowed.
- Back-to-back words: from IDLE after word_done, the next fifo_rd_en comes no earlier than the cycle after IDLE is entered. Minimum FIFO-pop-to-first-vld latency is 3 cycles (IDLE→RD_WAIT→LOAD→SEND drives vld on its first cycle if TX is idle).
- tx_en falling mid-word has no effect until IDLE. fifo_empty changing mid-word is ignored.
- uart_tx_data holds its last value between pulses. Only the value in the uart_tx_vld cycle is meaningful.

Test Plan:
- Single word:
  - Stimulus: FIFO holds 128'h00112233_44556677_8899AABB_CCDDEEFF; tx_en=1; UART TX model keeps busy high for 10 cycles per byte.
  - Required: exactly 16 uart_tx_vld pulses with bytes 00,11,22,…,FF in that order; one fifo_rd_en; word_done pulses once, after the 16th busy falls.
- Two words back-to-back:
  - Stimulus: FIFO holds 128'h0102…10 then 128'hF0F1…FF.
  - Required: 32 bytes in order, exactly 2 fifo_rd_en pulses, 2 word_done pulses, no vld while busy=1.
- Empty and disable:
  - Stimulus: fifo_empty=1 with tx_en=1 for 50 cycles; then fifo_empty=0 with tx_en=0 for 50 cycles.
  - Required: fifo_rd_en=0 and uart_tx_vld=0 throughout; busy=0.
- tx_en drop mid-word:
  - Stimulus: deassert tx_en after byte 5 while the FIFO still has 2 words.
  - Required: all 16 bytes of the current word are sent, word_done pulses, then the block stays in IDLE with no further fifo_rd_en.
- Reset mid-word:
  - Stimulus: assert s_rst_n=0 asynchronously during byte 8, release after 3 cycles; FIFO still non-empty.
  - Required: all outputs are 0 during reset; after release, a new fifo_rd_en; the first byte sent is the MSB byte of the next word.
- Slow/stalled TX:
  - Stimulus: busy is already high on entry to SEND and held for 100 cycles.
  - Required: no uart_tx_vld until busy=0; uart_tx_vld then asserts the cycle after busy falls; byte order is unchanged.
